// File: rtl/win_timer_if.sv
// Command and display bundle between the game controller and the run timer.
// Handshake: start/stop/clear are single-cycle pulses from the master, sampled on the rising edge of clk (no ready); all other signals are registered outputs of the timer.
interface win_timer_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] tmrs;
  logic [3:0] tmrms;
  logic [3:0] tmrmms;
  logic [3:0] best_s;
  logic [3:0] best_ms;
  logic [3:0] best_mms;
  logic       best_valid;
  logic       new_best;
  logic       running;
  logic       done;
  logic       overflow;
  logic [1:0] dbg_state;

  modport master (
    output start, stop, clear,
    input  tmrs, tmrms, tmrmms, best_s, best_ms, best_mms,
    input  best_valid, new_best, running, done, overflow, dbg_state
  );

  modport slave (
    input  start, stop, clear,
    output tmrs, tmrms, tmrmms, best_s, best_ms, best_mms,
    output best_valid, new_best, running, done, overflow, dbg_state
  );
endinterface

// File: rtl/win_timer.sv
// Hundredths-resolution BCD run timer with 9.99 s saturation and a best-time register.
// Commands resolve as clear > stop > start; only the winning command acts in a cycle.
module win_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic         clk,
  input  logic         rst,
  win_timer_if.slave   bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    s_q, s_d, ms_q, ms_d, mms_q, mms_d;
  logic [3:0]    bs_q, bs_d, bms_q, bms_d, bmms_q, bmms_d;
  logic          best_valid_q, best_valid_d;
  logic          new_best_q, new_best_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;

  logic cmd_clear, cmd_stop, cmd_start;
  logic tick, at_max, saturate, advance, better, upd_best;

  assign cmd_clear = bus.clear;
  assign cmd_stop  = !bus.clear && bus.stop;
  assign cmd_start = !bus.clear && !bus.stop && bus.start;

  // A tick coinciding with any command is dropped: the command owns the cycle.
  assign tick     = (state_q == S_RUN) && (presc_q == PRESC_LAST);
  assign at_max   = (s_q == 4'd9) && (ms_q == 4'd9) && (mms_q == 4'd9);
  assign saturate = tick && at_max && !cmd_clear && !cmd_stop && !cmd_start;
  assign advance  = tick && !at_max && !cmd_clear && !cmd_stop && !cmd_start;

  // BCD digits order the same way as their binary concatenation.
  assign better   = !best_valid_q || ({s_q, ms_q, mms_q} < {bs_q, bms_q, bmms_q});
  assign upd_best = cmd_stop && (state_q == S_RUN) && better;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (cmd_clear)      state_d = S_IDLE;
        else if (cmd_stop)  state_d = S_DONE;
        else if (cmd_start) state_d = S_RUN;
        else if (saturate)  state_d = S_DONE;
      end
      S_DONE: begin
        if (cmd_clear)      state_d = S_IDLE;
        else if (cmd_start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_comb begin
    presc_d = '0;
    if ((state_q == S_RUN) && (state_d == S_RUN) && !cmd_start) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    s_d   = s_q;
    ms_d  = ms_q;
    mms_d = mms_q;
    if (cmd_clear || cmd_start) begin
      s_d   = 4'd0;
      ms_d  = 4'd0;
      mms_d = 4'd0;
    end else if (advance) begin
      if (mms_q == 4'd9) begin
        mms_d = 4'd0;
        if (ms_q == 4'd9) begin
          ms_d = 4'd0;
          s_d  = s_q + 4'd1;
        end else begin
          ms_d = ms_q + 4'd1;
        end
      end else begin
        mms_d = mms_q + 4'd1;
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (cmd_clear || cmd_start) overflow_d = 1'b0;
    else if (saturate)          overflow_d = 1'b1;
  end

  always_comb begin
    bs_d         = bs_q;
    bms_d        = bms_q;
    bmms_d       = bmms_q;
    best_valid_d = best_valid_q;
    new_best_d   = upd_best;
    if (upd_best) begin
      bs_d         = s_q;
      bms_d        = ms_q;
      bmms_d       = mms_q;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      s_q          <= 4'd0;
      ms_q         <= 4'd0;
      mms_q        <= 4'd0;
      bs_q         <= 4'd0;
      bms_q        <= 4'd0;
      bmms_q       <= 4'd0;
      best_valid_q <= 1'b0;
      new_best_q   <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      s_q          <= s_d;
      ms_q         <= ms_d;
      mms_q        <= mms_d;
      bs_q         <= bs_d;
      bms_q        <= bms_d;
      bmms_q       <= bmms_d;
      best_valid_q <= best_valid_d;
      new_best_q   <= new_best_d;
      running_q    <= running_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.tmrs       = s_q;
  assign bus.tmrms      = ms_q;
  assign bus.tmrmms     = mms_q;
  assign bus.best_s     = bs_q;
  assign bus.best_ms    = bms_q;
  assign bus.best_mms   = bmms_q;
  assign bus.best_valid = best_valid_q;
  assign bus.new_best   = new_best_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/win_timer.md
# win_timer

Hundredths-resolution BCD stopwatch that measures the player's run time and feeds the win-screen display stage with three BCD digits: seconds, tenths, hundredths. Timing starts on a start pulse and freezes on the win (stop) pulse. The block saturates at 9.99 s and keeps a best-time register across rounds. It sits directly upstream of the win-condition display; its digit outputs connect straight to that stage's `tmrs`/`tmrms`/`tmrmms` inputs.

## Interface
- `CLK_HZ`, default 100_000_000: frequency of `clk` in Hz.
- `TICK_HZ`, default 100: count rate in Hz (one hundredth of a second). `CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `clk`  in  1  system clock. The single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: begin a new timing run.
- `stop`  in  1  one-cycle pulse: win event; freeze the time.
- `clear`  in  1  one-cycle pulse: abort or clear, then return to idle.
- `tmrs`  out  4  seconds digit, BCD 0–9.
- `tmrms`  out  4  tenths digit, BCD 0–9.
- `tmrmms`  out  4  hundredths digit, BCD 0–9.
- `best_s`, `best_ms`, `best_mms`  out  4 each  best-time digits, BCD.
- `best_valid`  out  1  a best time has been recorded.
- `new_best`  out  1  one-cycle pulse when the best time is updated.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `overflow`  out  1  the run saturated at 9.99; held until the next start, clear, or reset.

## Operation
- There are three states: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Command priority within one cycle is `clear` > `stop` > `start`. Only the highest-priority asserted command acts.
- **IDLE**
  - `start` → RUN. Digits are zeroed, the prescaler is zeroed, and `overflow` is cleared.
  - `stop` is ignored.
- **RUN**
  - The prescaler counts 0..DIV−1, where DIV = CLK_HZ/TICK_HZ. A tick occurs on the cycle where the count equals DIV−1; the count then wraps to 0.
  - On each tick, hundredths increment. At 9 the digit wraps to 0 and carries into tenths; tenths carry into seconds the same way.
  - A tick arriving while the digits read 9.99 does not wrap. The digits hold at 9.99, `overflow` is set, and the state goes to DONE. No best-time update occurs.
  - `stop` → DONE with the digits frozen. If a tick falls on the same cycle as `stop`, the tick is discarded.
  - `clear` → IDLE with the digits zeroed.
  - `start` restarts the run: digits and prescaler go to 0 and the state stays RUN.
- **DONE**
  - Digits hold their value.
  - `start` → RUN from 0, as from IDLE.
  - `clear` → IDLE with the digits zeroed and `overflow` cleared.
  - `stop` is ignored.
- **Best time**
  - Evaluated only on a RUN→DONE transition caused by `stop`.
  - The best time is updated when `best_valid` is 0, or when the frozen time is strictly less than the best. The comparison is BCD lexicographic: seconds, then tenths, then hundredths.
  - On update: load the best digits, set `best_valid`, and pulse `new_best`.
  - An equal time does not update.
  - `clear` does not erase the best time; only `rst` does.
- The prescaler is held at 0 outside RUN.

## Timing
- All outputs are registered. Reset values:
  - digits: 0
  - best digits: 0
  - `best_valid`: 0
  - `new_best`: 0
  - `running`: 0
  - `done`: 0
  - `overflow`: 0
- `start` sampled on edge N: `running`=1 after edge N. The first tick occurs on the DIV-th cycle of RUN, so `tmrmms` becomes 1 after edge N+DIV.
- `stop` sampled on edge M: `done`=1 and the digits are frozen after edge M. `new_best` is high for the cycle after edge M only.
- Digit carries ripple within a single edge: 0.99 → 1.00 in one tick.
- Asserting `rst` mid-run forces all outputs to their reset values immediately (asynchronously). Release is synchronous to `clk`.
- The inputs are single-cycle pulses synchronous to `clk`. A held level behaves as a repeat of the same command on every cycle, so a held `start` keeps restarting the run.

## Test plan
Use `CLK_HZ`=1000 and `TICK_HZ`=100, giving DIV=10.
- **Reset:** assert `rst` → all outputs 0, state IDLE. Then pulse `stop` → no change.
- **Count and carry:** pulse `start`, wait 10 cycles → 0.01. After 100 cycles → 0.10. After 1000 cycles → 1.00; check that 0.99→1.00 occurs on a single edge.
- **Stop and best:** `start`; `stop` after 2.34 s worth of ticks → digits freeze at 2.34, `done`=1, `new_best` pulses one cycle, best=2.34. Next run stopped at 3.00 → best stays 2.34 and there is no pulse. Next run stopped at 1.50 → best=1.50 with a pulse.
- **Overflow:** `start`, run 10 000 cycles → digits 9.99, `overflow`=1, `done`=1. Best is unchanged and there is no `new_best` pulse. Later ticks have no effect.
- **Simultaneous events:**
  - `stop` on the tick cycle at 0.04→0.05 → freeze at 0.04.
  - `clear`+`stop` on the same cycle → IDLE, digits 0.
  - `start` in RUN at 0.50 → digits 0.00, counting resumes.
- **Mid-run reset:** assert `rst` at 0.73 → digits 0, `best_valid`=0, `running`=0, applied asynchronously before the next clock edge.
